vga_charrom_timing_gen: RTL
===========================

// Module: vga_charrom_timing_gen
// PURPOSE
//  VGA raster timing generator feeding the character-ROM renderer. It is directly upstream of that renderer.
//  Walks h/v counters at pixel rate (clock-enable qualified) and presents the pixel coordinate and strobes
//  the renderer uses for glyph lookup. Emits hsync/vsync/de delayed to line up with the renderer's pixel output.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   hsync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync width, lines
//  V_BP       33   vertical back porch, lines
//  HSYNC_POL  0    asserted level of hsync (0 = active-low)
//  VSYNC_POL  0    asserted level of vsync
//  PIPE_DELAY 2    renderer latency in pixel ticks; legal range 0..7
//  CNT_W      11   counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clock       in   1      system clock; the only clock
//  reset       in   1      synchronous, active-high reset
//  pix_ce      in   1      pixel tick; all state advances only when it is 1
//  pix_x       out  CNT_W  current horizontal count, 0..H_TOTAL-1
//  pix_y       out  CNT_W  current vertical count, 0..V_TOTAL-1
//  pix_valid   out  1      (pix_x,pix_y) inside the active area
//  line_start  out  1      one-clock strobe when pix_x becomes 0
//  frame_start out  1      one-clock strobe when (pix_x,pix_y) becomes (0,0)
//  hsync_o     out  1      hsync, delayed PIPE_DELAY ticks
//  vsync_o     out  1      vsync, delayed PIPE_DELAY ticks
//  de_o        out  1      data enable (pix_valid), delayed PIPE_DELAY ticks
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Reset state: pix_x=0, pix_y=0, pix_valid=0, line_start=0, frame_start=0, de_o=0.
//    hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL. Every delay-line stage is cleared to these deasserted levels.
//  - Reset takes effect at any point, including mid-frame. There is no partial-frame recovery.
//  - First pix_ce after reset: presents (0,0), pix_valid=1, line_start=1, frame_start=1.
//  - On each clock with pix_ce=1, all registered outputs load from the next counter values:
//    - pix_x wraps at H_TOTAL-1 -> 0.
//    - pix_y increments only on that wrap; it wraps at V_TOTAL-1 -> 0.
//  - pix_ce=0: all outputs hold, including the delay line. line_start and frame_start drop to 0
//    (each strobe is high for exactly one clock).
//  - pix_ce held at 1 permanently is legal: one pixel per clock.
//  - pix_valid = (pix_x<H_ACTIVE) && (pix_y<V_ACTIVE). It is registered together with the coordinates (0 latency vs pix_x).
//  - Raw hsync asserted for H_ACTIVE+H_FP <= pix_x < H_ACTIVE+H_FP+H_SYNC (656..751).
//  - Raw vsync asserted for V_ACTIVE+V_FP <= pix_y < V_ACTIVE+V_FP+V_SYNC (490..491), across the whole line.
//  - Raw hsync, vsync and pix_valid pass through a PIPE_DELAY-stage shift register that advances on pix_ce only.
//    Outputs are hsync_o, vsync_o, de_o. PIPE_DELAY=0 means they equal the raw registered values.
//  - Sync output levels: asserted = POL, deasserted = ~POL.
//  - Horizontal phase FSM (H_ACT -> H_FP -> H_SYN -> H_BP -> H_ACT) is decoded from counter compares.
//    The vertical phase FSM is decoded the same way. The FSMs carry no extra state beyond the counters.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - vga_timing_pkg: default 640x480@60 constants, H_TOTAL/V_TOTAL functions, typedef vga_coord_t.
//  - Sub-module vga_delay_line: parameterised depth/width, ce-gated shift register with sync reset to a RESET_VAL.
//  - One instance carries {hsync, vsync, de}.
// TESTING
//  - Reset asserted 10 clocks, pix_ce=1 -> during reset hsync_o=vsync_o=1, de_o=0.
//    First tick after release gives pix_x=0, pix_y=0, frame_start=1.
//  - pix_ce=1 continuous -> line_start every 800 clocks; frame_start every 420000 clocks.
//    pix_y reaches 524 then wraps to 0.
//  - Scan one line, PIPE_DELAY=2 -> hsync_o low for exactly 96 ticks, first low 2 ticks after pix_x=656.
//    de_o high for 640 ticks.
//  - Scan one frame -> vsync_o low on lines 490 and 491 only. de_o never high when pix_y>=480.
//  - pix_ce toggling 1-of-5 (125->25 MHz), then held 0 for 37 clocks mid-line -> outputs frozen.
//    Scan resumes at the next pix_x with no skipped or repeated coordinate.
//  - Reset pulsed at (pix_x=300, pix_y=200) -> next presented position is (0,0) with frame_start=1.
//    Delay line flushed to deasserted levels.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480@60 defaults), total-count helpers
// and the phase encoding used by the horizontal/vertical decoders.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 11;

  typedef logic [DEF_CNT_W-1:0] vga_coord_t;

  typedef enum logic [1:0] {
    PH_ACT = 2'd0,
    PH_FP  = 2'd1,
    PH_SYN = 2'd2,
    PH_BP  = 2'd3
  } vga_phase_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Phase of a position along one axis; back porch is whatever remains.
  function automatic vga_phase_t phase_of(input int pos, input int active, input int fp,
                                          input int sync);
    if (pos < active)                  return PH_ACT;
    else if (pos < active + fp)        return PH_FP;
    else if (pos < active + fp + sync) return PH_SYN;
    else                               return PH_BP;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register; every stage resets to RESET_VAL so a
// reset flushes the line to a known level. DEPTH=0 is a straight wire.
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else if (ce) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_charrom_timing_gen.sv
// VGA raster timing generator for the character-ROM renderer: pixel-rate
// h/v counters, coordinate strobes and syncs aligned to renderer latency.
//
// phase  | meaning (same encoding for horizontal and vertical axis)
// PH_ACT | visible pixels / lines
// PH_FP  | front porch
// PH_SYN | sync pulse asserted
// PH_BP  | back porch, then wrap to PH_ACT
module vga_charrom_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 2,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_valid,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Set by reset so the first tick presents (0,0) rather than (1,0).
  logic             first_tick;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  vga_phase_t       h_phase;
  vga_phase_t       v_phase;
  logic             hsync_raw;
  logic             vsync_raw;

  always_comb begin
    x_next = pix_x + 1'b1;
    y_next = pix_y;
    if (first_tick) begin
      x_next = '0;
      y_next = '0;
    end else if (pix_x == H_LAST) begin
      x_next = '0;
      y_next = (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
    end
    h_phase = phase_of(int'(x_next), H_ACTIVE, H_FP, H_SYNC);
    v_phase = phase_of(int'(y_next), V_ACTIVE, V_FP, V_SYNC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      first_tick  <= 1'b1;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync_raw   <= ~HSYNC_POL;
      vsync_raw   <= ~VSYNC_POL;
    end else if (pix_ce) begin
      first_tick  <= 1'b0;
      pix_x       <= x_next;
      pix_y       <= y_next;
      pix_valid   <= (h_phase == PH_ACT) && (v_phase == PH_ACT);
      line_start  <= (x_next == '0);
      frame_start <= (x_next == '0) && (y_next == '0);
      hsync_raw   <= (h_phase == PH_SYN) ? HSYNC_POL : ~HSYNC_POL;
      vsync_raw   <= (v_phase == PH_SYN) ? VSYNC_POL : ~VSYNC_POL;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  vga_delay_line #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (3),
    .RESET_VAL ({~HSYNC_POL, ~VSYNC_POL, 1'b0})
  ) u_sync_delay (
    .clock (clock),
    .reset (reset),
    .ce    (pix_ce),
    .din   ({hsync_raw, vsync_raw, pix_valid}),
    .dout  ({hsync_o, vsync_o, de_o})
  );

endmodule
